// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
// The FSM states mirror the transmitter start/busy handshake.
package uart_arb_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int MAX_BURST_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// Shared by the shared-peripheral arbiters.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            any
);

  logic          found_s;
  logic [PW:0]   sum_s;
  logic [PW-1:0] idx_s;

  // Scan from ptr upward; ptr and offset are both below NREQ, so one subtraction wraps.
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_s = {1'b0, ptr} + (PW+1)'(i);
      if (sum_s >= (PW+1)'(NREQ)) begin
        idx_s = PW'(sum_s - (PW+1)'(NREQ));
      end else begin
        idx_s = PW'(sum_s);
      end
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter_chk.sv
// Protocol assertions for uart_tx_arbiter outputs.
// Grant ownership, ready qualification and start-pulse width.
module uart_tx_arbiter_chk #(
  parameter int NREQ = 4
) (
  input logic            clk,
  input logic            resetn,
  input logic [NREQ-1:0] grant,
  input logic [NREQ-1:0] req_ready,
  input logic            tx_start
);

  a_grant_onehot: assert property (@(posedge clk) disable iff (!resetn)
    $onehot0(grant));

  a_ready_owner_only: assert property (@(posedge clk) disable iff (!resetn)
    (req_ready & ~grant) == '0);

  a_start_single_cycle: assert property (@(posedge clk) disable iff (!resetn)
    tx_start |=> !tx_start);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locked, burst-capped sharing of one uart_tx byte transmitter.
// Requesters see valid/ready; the block drives the tx_start/tx_busy handshake.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e      state_r;
  logic [NREQ-1:0] grant_r;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   idx_r;
  logic [CW-1:0]   cnt_r;
  logic            last_r;
  logic            tx_start_r;
  logic [7:0]      tx_data_r;

  logic [NREQ-1:0] pick_gnt_s;
  logic            pick_any_s;
  logic [PW-1:0]   pick_idx_s;
  logic            own_valid_s;
  logic [7:0]      own_data_s;
  logic            own_last_s;
  logic [PW-1:0]   ptr_next_s;
  logic            release_s;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_r),
    .gnt (pick_gnt_s),
    .any (pick_any_s)
  );

  // Index of the one-hot pick, kept so the pointer can advance past the owner.
  always_comb begin
    pick_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt_s[i]) begin
        pick_idx_s = PW'(i);
      end else begin
        pick_idx_s = pick_idx_s;
      end
    end
  end

  // One-hot mux of the owner's valid, byte and last flag.
  always_comb begin
    own_valid_s = 1'b0;
    own_data_s  = 8'h00;
    own_last_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_r[i]) begin
        own_valid_s = own_valid_s | req_valid[i];
        own_data_s  = own_data_s | req_data[8*i +: 8];
        own_last_s  = own_last_s | req_last[i];
      end else begin
        own_valid_s = own_valid_s;
      end
    end
  end

  // Pointer moves to the requester after the releasing owner.
  always_comb begin
    if (idx_r == PW'(NREQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = idx_r + PW'(1);
    end
  end

  // Owner releases on a recorded last byte or on reaching the burst cap.
  always_comb begin
    if (last_r || (cnt_r == CW'(MAX_BURST - 1))) begin
      release_s = 1'b1;
    end else begin
      release_s = 1'b0;
    end
  end

  // Only the owner may be ready, only in FETCH, and only while the transmitter is free.
  always_comb begin
    if ((state_r == FETCH) && !tx_busy) begin
      req_ready = grant_r;
    end else begin
      req_ready = '0;
    end
  end

  // Arbitration and transmit-handshake FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= IDLE;
      grant_r    <= '0;
      ptr_r      <= '0;
      idx_r      <= '0;
      cnt_r      <= '0;
      last_r     <= 1'b0;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      tx_start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            grant_r <= pick_gnt_s;
            idx_r   <= pick_idx_s;
            cnt_r   <= '0;
            state_r <= FETCH;
          end
        end
        FETCH: begin
          if (!own_valid_s) begin
            grant_r <= '0;
            ptr_r   <= ptr_next_s;
            state_r <= IDLE;
          end else if (!tx_busy) begin
            tx_data_r  <= own_data_s;
            last_r     <= own_last_s;
            tx_start_r <= 1'b1;
            state_r    <= START;
          end
        end
        START: begin
          state_r <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_r <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (release_s) begin
              grant_r <= '0;
              ptr_r   <= ptr_next_s;
              state_r <= IDLE;
            end else begin
              cnt_r   <= cnt_r + CW'(1);
              state_r <= FETCH;
            end
          end
        end
        default: begin
          grant_r <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign grant    = grant_r;
  assign tx_start = tx_start_r;
  assign tx_data  = tx_data_r;

  uart_tx_arbiter_chk #(
    .NREQ (NREQ)
  ) u_chk (
    .clk       (clk),
    .resetn    (resetn),
    .grant     (grant),
    .req_ready (req_ready),
    .tx_start  (tx_start)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx busy model.
// Stimulus loads requester queues; a monitor checks every tx_start against expectations.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int MAXB = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  logic [8:0]      rq [NREQ][$];
  logic [11:0]     expq[$];
  logic [3:0]      glog[$];
  logic [3:0]      eglog[$];
  logic [NREQ-1:0] fire;
  int              ntests = 0;
  int              nfail = 0;
  int              nstart = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [7:0] d);
    expq.push_back({g, d});
  endtask

  function automatic bit rq_empty();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string nm);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #3;
      if (expq.size() == 0 && rq_empty() && grant == 4'b0000 && !tx_busy) return;
    end
    chk({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic chk_glog(input string nm);
    chk({nm, "_glog_len"}, glog.size(), eglog.size());
    for (int i = 0; i < glog.size() && i < eglog.size(); i++)
      chk($sformatf("%s_glog[%0d]", nm, i), glog[i], eglog[i]);
    glog.delete();
    eglog.delete();
  endtask

  // Requester driver: present queue heads, pop on accepted handshakes.
  initial begin
    req_valid = '0; req_data = '0; req_last = '0; fire = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i] = rq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i] = 1'b0;
        end
      end
      #1;
      fire = req_valid & req_ready;
    end
  end

  // uart_tx model: busy for four cycles after each start pulse.
  initial begin
    int bcnt;
    tx_busy = 1'b0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) tx_busy = 1'b0;
      end else if (tx_start) begin
        tx_busy = 1'b1;
        bcnt = 4;
      end
    end
  end

  // Monitor: grant trace, ready qualification and scoreboard on tx_start.
  initial begin
    logic [3:0] last_g;
    logic       prev_start;
    logic [11:0] e;
    last_g = 4'b0000;
    prev_start = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (grant !== last_g) begin
        glog.push_back(grant);
        last_g = grant;
      end
      if (req_ready != 4'b0000) chk("ready_owner_only", 32'(req_ready & ~grant), 32'd0);
      if (tx_start) begin
        nstart++;
        chk("start_one_cycle", 32'(prev_start), 32'd0);
        if (expq.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL unexpected_tx_start: got grant %b data %h expected none", grant, tx_data);
        end else begin
          e = expq.pop_front();
          chk("tx_byte{grant,data}", 32'({grant, tx_data}), 32'(e));
        end
      end
      prev_start = tx_start;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    bit found;
    // Reset state; contention stimulus loaded while held in reset.
    repeat (2) @(negedge clk);
    #3;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_ptr", 32'(dut.ptr_r), 32'd0);
    load(0, 8'hAA, 1'b1);
    load(2, 8'hBB, 1'b1);
    push_exp(4'b0001, 8'hAA);
    push_exp(4'b0100, 8'hBB);
    eglog = '{4'b0001, 4'b0000, 4'b0100, 4'b0000};
    @(negedge clk);
    resetn = 1'b1;
    wait_idle("contention");
    chk_glog("contention");
    chk("ptr_after_contention", 32'(dut.ptr_r), 32'd3);

    // Pointer wrap: ptr=3 favours requester 3 over 0.
    load(0, 8'h30, 1'b1);
    load(3, 8'h3F, 1'b1);
    push_exp(4'b1000, 8'h3F);
    push_exp(4'b0001, 8'h30);
    eglog = '{4'b1000, 4'b0000, 4'b0001, 4'b0000};
    wait_idle("wrap");
    chk_glog("wrap");
    chk("ptr_after_wrap", 32'(dut.ptr_r), 32'd1);

    // Single three-byte frame with latency checks on the first byte.
    load(0, 8'h48, 1'b0);
    load(0, 8'h69, 1'b0);
    load(0, 8'h0A, 1'b1);
    push_exp(4'b0001, 8'h48);
    push_exp(4'b0001, 8'h69);
    push_exp(4'b0001, 8'h0A);
    eglog = '{4'b0001, 4'b0000};
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #3;
      if (req_valid[0]) found = 1'b1;
    end
    chk("lat_valid_seen", 32'(found), 32'd1);
    chk("lat_t_grant", 32'(grant), 32'd0);
    @(negedge clk); #3;
    chk("lat_t1_grant", 32'(grant), 32'b0001);
    chk("lat_t1_ready", 32'(req_ready), 32'b0001);
    @(negedge clk); #3;
    chk("lat_t2_tx_start", 32'(tx_start), 32'd1);
    chk("lat_t2_tx_data", 32'(tx_data), 32'h48);
    wait_idle("single");
    chk_glog("single");
    chk("ptr_after_single", 32'(dut.ptr_r), 32'd1);

    // Burst cap of 4: requester 1 streams 6 bytes, requester 3 cuts in after 4.
    for (int b = 0; b < 6; b++) load(1, 8'(8'h10 + b), 1'b0);
    load(3, 8'h33, 1'b1);
    for (int b = 0; b < 4; b++) push_exp(4'b0010, 8'(8'h10 + b));
    push_exp(4'b1000, 8'h33);
    push_exp(4'b0010, 8'h14);
    push_exp(4'b0010, 8'h15);
    eglog = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000};
    wait_idle("burst");
    chk_glog("burst");
    chk("ptr_after_burst", 32'(dut.ptr_r), 32'd2);

    // Abandoned frame: valid drops after two of five bytes.
    load(1, 8'h21, 1'b0);
    load(1, 8'h22, 1'b0);
    push_exp(4'b0010, 8'h21);
    push_exp(4'b0010, 8'h22);
    eglog = '{4'b0010, 4'b0000};
    wait_idle("abandon");
    chk_glog("abandon");
    saved = nstart;
    repeat (20) @(negedge clk);
    chk("abandon_no_restart", 32'(nstart), 32'(saved));
    load(1, 8'h23, 1'b0);
    load(1, 8'h24, 1'b0);
    load(1, 8'h25, 1'b1);
    push_exp(4'b0010, 8'h23);
    push_exp(4'b0010, 8'h24);
    push_exp(4'b0010, 8'h25);
    eglog = '{4'b0010, 4'b0000};
    wait_idle("abandon_resume");
    chk_glog("abandon_resume");
    chk("ptr_after_abandon", 32'(dut.ptr_r), 32'd2);

    // Reset mid-frame during WAIT_DONE, then arbitration from ptr 0.
    load(2, 8'h41, 1'b0);
    load(2, 8'h42, 1'b0);
    load(2, 8'h43, 1'b1);
    push_exp(4'b0100, 8'h41);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk); #3;
      if (tx_busy) found = 1'b1;
    end
    chk("mid_busy_seen", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    #3;
    chk("pre_reset_state", 32'(dut.state_r), 32'(WAIT_DONE));
    resetn = 1'b0;
    rq[2].delete();
    #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_ptr", 32'(dut.ptr_r), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    glog.delete();
    load(1, 8'h51, 1'b1);
    load(3, 8'h53, 1'b1);
    push_exp(4'b0010, 8'h51);
    push_exp(4'b1000, 8'h53);
    eglog = '{4'b0010, 4'b0000, 4'b1000, 4'b0000};
    wait_idle("post_reset");
    chk_glog("post_reset");
    chk("ptr_after_post_reset", 32'(dut.ptr_r), 32'd0);
    chk("exp_drained", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` byte transmitter between `NREQ` independent byte-stream requesters. Grants are round-robin, locked per frame (until `last`), and capped at `MAX_BURST` bytes. The block sequences the transmitter's `tx_start`/`tx_busy` handshake so requesters see a plain valid/ready byte interface. It sits between the on-chip debug/status producers and the single board UART TX pin driver.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: maximum bytes per grant, 1..256.

- `clk`  in  1  system clock, shared with `uart_tx`.
- `resetn`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  NREQ  requester i has a byte on its data slice.
- `req_data`  in  8*NREQ  byte for requester i on bits [8i+7:8i].
- `req_last`  in  NREQ  the presented byte ends the frame.
- `req_ready`  out  NREQ  byte accepted this cycle when paired with `req_valid[i]`.
- `grant`  out  NREQ  one-hot current owner; all-zero when no owner.
- `tx_start`  out  1  single-cycle start pulse to `uart_tx`.
- `tx_data`  out  8  byte to `uart_tx`; held stable from `tx_start` until the transmitter is busy.
- `tx_busy`  in  1  busy flag from `uart_tx`.

## Operation
- FSM states:
  - IDLE: if `req_valid` is nonzero, pick the first valid index at or after `ptr`, wrapping. Load `grant` one-hot, clear `cnt`, go to FETCH. Otherwise stay.
  - FETCH: `req_ready[g] = ~tx_busy` (combinational, owner only).
    - If `req_valid[g]` and `~tx_busy`: register the data into `tx_data`, record `last`, go to START.
    - If `req_valid[g]` is low: the frame is abandoned. Clear `grant`, set `ptr = g+1` mod NREQ, go to IDLE.
  - START: `tx_start = 1` for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: when `tx_busy == 1`, go to WAIT_DONE.
  - WAIT_DONE: when `tx_busy == 0`:
    - If the recorded `last` is set, or `cnt == MAX_BURST-1`: clear `grant`, set `ptr = g+1` mod NREQ, go to IDLE.
    - Otherwise increment `cnt` and go to FETCH.
- `req_ready` is zero for non-owners, and zero in every state except FETCH.
- `ptr` wraps from NREQ-1 to 0. `cnt` is ceil(log2(MAX_BURST+1)) bits wide and never exceeds MAX_BURST-1.
- Only one byte is ever in flight. The block does not buffer beyond `tx_data`.

## Timing
- Reset values: state IDLE, `grant` 0, `ptr` 0, `cnt` 0, `tx_start` 0, `tx_data` 0x00. `req_ready` is 0.
- Reset asserted mid-frame returns all of the above immediately. The byte already inside `uart_tx` completes on its own.
- Latency from IDLE with valid high at cycle t:
  - grant at t+1;
  - `req_ready` at t+1, byte accepted at t+1;
  - `tx_start` at t+2.
- Back-to-back bytes: `tx_busy` falls seen at cycle u; FETCH at u+1; `tx_start` at u+2.
- Simultaneous valids in IDLE: the lowest index at or after `ptr` wins. The others wait, with no byte lost, because their ready stays low.
- A new valid arriving while another requester owns the grant is ignored until IDLE.
- A requester asserting `req_last` on its MAX_BURST-th byte releases once; there is no double pointer advance.

## Structure
- Package `uart_arb_pkg`: FSM state enum (IDLE, FETCH, START, WAIT_BUSY, WAIT_DONE) and the default `NREQ`/`MAX_BURST` constants.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are `req[NREQ]` and `ptr`; outputs are one-hot `gnt` and `any`. It is reused by future shared-peripheral arbiters.
- The transmitter (`uart_tx`) is instantiated outside this block at the top level.

## Test plan
- Single frame: requester 0 sends 0x48, 0x69, 0x0A with `last` on 0x0A. Required response:
  - exactly 3 `tx_start` pulses with those `tx_data` values, in order;
  - `grant` = 0001 throughout;
  - `ptr` = 1 after the frame.
- Contention: requesters 0 and 2 both valid from reset, each with a 1-byte frame (0xAA and 0xBB). Required response:
  - 0xAA transmitted first, then 0xBB;
  - `grant` sequence 0001 → 0000 → 0100;
  - requester 2 `req_ready` stays 0 during requester 0's transfer.
- Burst cap: `MAX_BURST` = 4, requester 1 streams 6 bytes with no `last`, and requester 3 is valid. Required response:
  - after 4 bytes, `grant` moves to 1000;
  - requester 1 resumes only after requester 3's frame.
- Abandoned frame: requester 1 drops `req_valid` after byte 2 of 5. Required response:
  - `grant` clears in FETCH;
  - no further `tx_start` is issued for requester 1 until its next IDLE win.
- Pointer wrap: `ptr` = 3 with requesters 0 and 3 valid. Required response: requester 3 wins, then requester 0, and `ptr` ends at 1.
- Reset mid-frame: pull `resetn` low during WAIT_DONE. Required response:
  - `grant` = 0, `tx_start` = 0, `req_ready` = 0 asynchronously;
  - after release, arbitration restarts from `ptr` = 0.
